// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state encoding and sizing helper for reset_sequencer
package reset_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    HOLD  = 2'd0,
    WAIT  = 2'd1,
    RUN   = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Bits needed to hold values 0..v-1; never less than one so a degenerate size still yields a real vector.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release controller
// Holds all stage resets, then releases them in index order gated by per-stage ready with a timeout.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] reset_out,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = clog2(CNT_MAX);
  localparam int IDX_W   = clog2(NUM_STAGES);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] NEXT_BIT = NUM_STAGES'(2);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES-1:0]   reset_out_q, reset_out_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic                    cur_ready;

  assign cur_ready = stage_ready[idx_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    reset_out_d = reset_out_q;
    done_d      = done_q;
    error_d     = error_q;

    // A software request pre-empts everything and keeps the hold counter pinned at zero.
    if (sw_reset_req) begin
      state_d     = HOLD;
      cnt_d       = '0;
      idx_d       = '0;
      reset_out_d = '1;
      done_d      = 1'b0;
      error_d     = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d        = WAIT;
            reset_out_d[0] = 1'b0;
            idx_d          = '0;
            cnt_d          = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        WAIT: begin
          if (cur_ready) begin
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              reset_out_d = reset_out_q & ~(NEXT_BIT << idx_q);
              idx_d       = idx_q + IDX_W'(1);
              cnt_d       = '0;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN:     ;
        ERROR:   ;
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      reset_out_q <= '1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      reset_out_q <= reset_out_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign reset_out = reset_out_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;

  localparam int N = 3;
  localparam int H = 16;
  localparam int T = 256;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         sw_reset_req = 1'b0;
  logic [N-1:0] stage_ready = '0;
  logic [N-1:0] reset_out;
  logic         done;
  logic         error;

  int checks = 0;
  int errors = 0;

  // Reference model: how many stages are released, how long the current phase has lasted.
  bit m_in_hold;
  int m_hold_age;
  int m_rel;
  int m_wait_age;
  bit m_done;
  bit m_err;

  reset_sequencer #(
    .NUM_STAGES    (N),
    .HOLD_CYCLES   (H),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .sw_reset_req(sw_reset_req),
    .stage_ready (stage_ready),
    .reset_out   (reset_out),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    m_in_hold  = 1'b1;
    m_hold_age = 0;
    m_rel      = 0;
    m_wait_age = 0;
    m_done     = 1'b0;
    m_err      = 1'b0;
  endfunction

  function automatic void model_edge(input bit s, input logic [N-1:0] r);
    if (s) begin
      model_clear();
    end else if (m_in_hold) begin
      m_hold_age++;
      if (m_hold_age == H) begin
        m_in_hold  = 1'b0;
        m_rel      = 1;
        m_wait_age = 0;
      end
    end else if (!m_done && !m_err) begin
      if (r[m_rel-1]) begin
        if (m_rel == N) m_done = 1'b1;
        else begin
          m_rel++;
          m_wait_age = 0;
        end
      end else if (m_wait_age == T - 1) begin
        m_err = 1'b1;
      end else begin
        m_wait_age++;
      end
    end
  endfunction

  function automatic logic [N-1:0] model_rst();
    logic [N-1:0] m;
    m = '1;
    for (int i = 0; i < N; i++) if (i < m_rel) m[i] = 1'b0;
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    check("reset_out", 32'(reset_out), 32'(model_rst()));
    check("done", 32'(done), 32'(m_done));
    check("error", 32'(error), 32'(m_err));
  endtask

  task automatic step(input bit s, input logic [N-1:0] r);
    sw_reset_req = s;
    stage_ready  = r;
    @(posedge clk);
    model_edge(s, r);
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [N-1:0] rand_ready(input int mode);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       r[i] = 1'($urandom_range(0, 1));
        1:       r[i] = ($urandom_range(0, 299) == 0);
        default: r[i] = ($urandom_range(0, 9) != 0);
      endcase
    end
    return r;
  endfunction

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_reset_out", 32'(reset_out), 32'h7);
    check("rst_done", 32'(done), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    areset = 1'b0;

    // Power-up with all stages ready.
    for (int e = 1; e <= 20; e++) begin
      step(1'b0, 3'b111);
      if (e == 15) check("pu_e15", 32'(reset_out), 32'h7);
      if (e == 16) check("pu_e16", 32'(reset_out), 32'h6);
      if (e == 17) check("pu_e17", 32'(reset_out), 32'h4);
      if (e == 18) begin
        check("pu_e18", 32'(reset_out), 32'h0);
        check("pu_e18_done", 32'(done), 32'h0);
      end
      if (e == 19) check("pu_e19_done", 32'(done), 32'h1);
    end
    check("pu_error", 32'(error), 32'h0);

    // Software request held three cycles while running.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'b111);
      check("sw_run_rst", 32'(reset_out), 32'h7);
      check("sw_run_done", 32'(done), 32'h0);
    end
    for (int e = 1; e <= 19; e++) begin
      step(1'b0, 3'b111);
      if (e == 15) check("sw_e15", 32'(reset_out), 32'h7);
      if (e == 16) check("sw_e16", 32'(reset_out), 32'h6);
    end
    check("sw_done_again", 32'(done), 32'h1);

    // Slow acknowledge on stage 1.
    step(1'b1, 3'b001);
    for (int e = 1; e <= 17; e++) step(1'b0, 3'b001);
    check("slow_e17", 32'(reset_out), 32'h4);
    for (int j = 1; j <= 39; j++) step(1'b0, 3'b001);
    check("slow_wait", 32'(reset_out), 32'h4);
    step(1'b0, 3'b011);
    check("slow_release", 32'(reset_out), 32'h0);
    check("slow_noerr", 32'(error), 32'h0);
    step(1'b0, 3'b111);
    check("slow_done", 32'(done), 32'h1);

    // Stage 1 never acknowledges: timeout 256 edges after WAIT(1) entry at edge 17.
    step(1'b1, 3'b001);
    for (int e = 1; e <= 272; e++) step(1'b0, 3'b001);
    check("to_before", 32'(error), 32'h0);
    step(1'b0, 3'b001);
    check("to_error", 32'(error), 32'h1);
    check("to_rst", 32'(reset_out), 32'h4);
    for (int i = 0; i < 20; i++) step(1'b0, 3'b111);
    check("to_sticky", 32'(error), 32'h1);
    check("to_nodone", 32'(done), 32'h0);
    check("to_held", 32'(reset_out), 32'h4);

    // Leave ERROR via a one-cycle software request.
    step(1'b1, 3'b111);
    check("err_clear", 32'(error), 32'h0);
    for (int e = 1; e <= 19; e++) step(1'b0, 3'b111);
    check("err_recover_done", 32'(done), 32'h1);

    // Ready arriving on the timeout edge wins.
    step(1'b1, 3'b001);
    for (int e = 1; e <= 272; e++) step(1'b0, 3'b001);
    step(1'b0, 3'b011);
    check("edge_noerr", 32'(error), 32'h0);
    check("edge_rst", 32'(reset_out), 32'h0);

    // Request and ready together: the request wins.
    step(1'b1, 3'b111);
    check("sw_vs_ready", 32'(reset_out), 32'h7);

    // Randomized segments.
    for (int seg = 0; seg < 16; seg++) begin
      int mode;
      int len;
      int sw_odds;
      mode    = $urandom_range(0, 2);
      len     = $urandom_range(50, 400);
      sw_odds = (mode == 1) ? 400 : 60;
      for (int c = 0; c < len; c++)
        step($urandom_range(0, sw_odds - 1) == 0, rand_ready(mode));
    end

    // Asynchronous reset while waiting on stage 1.
    step(1'b1, 3'b001);
    for (int e = 1; e <= 20; e++) step(1'b0, 3'b001);
    check("ar_pre", 32'(reset_out), 32'h4);
    #2 areset = 1'b1;
    #1;
    model_clear();
    check("ar_rst", 32'(reset_out), 32'h7);
    check("ar_done", 32'(done), 32'h0);
    check("ar_error", 32'(error), 32'h0);
    @(negedge clk);
    areset = 1'b0;
    for (int e = 1; e <= 280; e++) step(1'b0, 3'b001);
    check("ar_then_err", 32'(error), 32'h1);

    // Asynchronous reset from ERROR clears the sticky flag without a clock.
    #2 areset = 1'b1;
    #1;
    model_clear();
    check("ar_err_clear", 32'(error), 32'h0);
    check("ar_err_rst", 32'(reset_out), 32'h7);
    @(negedge clk);
    areset = 1'b0;
    for (int e = 1; e <= 20; e++) step(1'b0, 3'b111);
    check("ar_final_done", 32'(done), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
